// File: rtl/sw_debounce_pkg.sv
// Shared widths and sizing helper for the sw_debounce switch-conditioning stage.
package sw_debounce_pkg;

   localparam int SW_W      = 8;
   localparam int EVT_CNT_W = 8;
   localparam int DIG_W     = 4;

   // Ceiling log2 that never returns less than 1, so a counter always has a bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/sw_deb_bit.sv
// One debounced switch bit: stability counter, level register and edge pulses.
module sw_deb_bit
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_N = 4,
   parameter int CNT_W    = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic tick,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

   logic [CNT_W-1:0] cnt;

   // Pulses default low every cycle; only a qualifying tick raises one of them.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt  <= '0;
         db   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            if (raw == db) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt  <= '0;
               db   <= ~db;
               rise <= ~db;
               fall <= db;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the 8-bit CPLD switch word and drives the two display hex digits.
// Define SW_DEBOUNCE_EVT_CNT_EN to show a rising-edge event counter instead of sw_db.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int SAMPLE_DIV = 16384,
   parameter int STABLE_N   = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [SW_W-1:0]  sw_raw,
   input  logic             cnt_clr,
   output logic [SW_W-1:0]  sw_db,
   output logic [SW_W-1:0]  sw_rise,
   output logic [SW_W-1:0]  sw_fall,
   output logic [DIG_W-1:0] dig0,
   output logic [DIG_W-1:0] dig1
);

   localparam int PRE_W = clog2_min1(SAMPLE_DIV);
   localparam int STB_W = clog2_min1(STABLE_N);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;

   // Free-running sample prescaler; one tick per CPLD frame.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   for (genvar i = 0; i < SW_W; i++) begin : g_bit
      sw_deb_bit #(
         .STABLE_N (STABLE_N),
         .CNT_W    (STB_W)
      ) u_bit (
         .clk  (clk),
         .rstn (rstn),
         .tick (tick),
         .raw  (sw_raw[i]),
         .db   (sw_db[i]),
         .rise (sw_rise[i]),
         .fall (sw_fall[i])
      );
   end

`ifdef SW_DEBOUNCE_EVT_CNT_EN
   logic [EVT_CNT_W-1:0] evt_cnt;

   // Counts cycles with any rising edge, not the number of bits that rose.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         evt_cnt <= '0;
      end else if (cnt_clr) begin
         evt_cnt <= '0;
      end else if (|sw_rise) begin
         evt_cnt <= evt_cnt + 1'b1;
      end
   end

   assign dig0 = evt_cnt[DIG_W-1:0];
   assign dig1 = evt_cnt[2*DIG_W-1:DIG_W];
`else
   logic cnt_clr_unused;

   assign cnt_clr_unused = cnt_clr;
   assign dig0 = sw_db[DIG_W-1:0];
   assign dig1 = sw_db[2*DIG_W-1:DIG_W];
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with SAMPLE_DIV=4, STABLE_N=3; works with or without the counter macro.
module tb_sw_debounce;

   localparam int SAMPLE_DIV = 4;
   localparam int STABLE_N   = 3;

   typedef struct packed {
      logic [7:0] db;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [3:0] d0;
      logic [3:0] d1;
   } exp_t;

   logic       clk;
   logic       rstn;
   logic [7:0] sw_raw;
   logic       cnt_clr;
   logic [7:0] sw_db;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;
   logic [3:0] dig0;
   logic [3:0] dig1;

   int   nVec;
   int   nFail;
   exp_t expQ[$];
   logic monEnable;

   sw_debounce #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .STABLE_N   (STABLE_N)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sw_raw  (sw_raw),
      .cnt_clr (cnt_clr),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .dig0    (dig0),
      .dig1    (dig1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a bit flips once its last STABLE_N tick samples all disagree with its level.
   initial begin : refModel
      int         cycSinceRst;
      bit         hist[8][$];
      logic [7:0] mDb, mRise, mFall, nRise, nFall;
      logic [7:0] mCnt;
      bit         tickNow, allDiff;
      exp_t       e;
      cycSinceRst = 0;
      mDb = 0; mRise = 0; mFall = 0; mCnt = 0;
      forever begin
         @(posedge clk);
         if (!rstn) begin
            cycSinceRst = 0;
            mDb = 0; mRise = 0; mFall = 0; mCnt = 0;
            for (int i = 0; i < 8; i++) hist[i].delete();
         end else begin
            tickNow = ((cycSinceRst % SAMPLE_DIV) == SAMPLE_DIV - 1);
            cycSinceRst++;
            if (cnt_clr) mCnt = 0;
            else if (mRise != 0) mCnt = mCnt + 8'd1;
            nRise = 0; nFall = 0;
            if (tickNow) begin
               for (int i = 0; i < 8; i++) begin
                  hist[i].push_back(sw_raw[i]);
                  if (hist[i].size() > STABLE_N) void'(hist[i].pop_front());
                  allDiff = (hist[i].size() == STABLE_N);
                  foreach (hist[i][k]) if (hist[i][k] == mDb[i]) allDiff = 0;
                  if (allDiff) begin
                     if (mDb[i]) nFall[i] = 1'b1;
                     else        nRise[i] = 1'b1;
                     mDb[i] = ~mDb[i];
                     hist[i].delete();
                  end
               end
            end
            mRise = nRise;
            mFall = nFall;
         end
         e.db = mDb; e.rise = mRise; e.fall = mFall;
`ifdef SW_DEBOUNCE_EVT_CNT_EN
         e.d0 = mCnt[3:0]; e.d1 = mCnt[7:4];
`else
         e.d0 = mDb[3:0];  e.d1 = mDb[7:4];
`endif
         if (monEnable) expQ.push_back(e);
      end
   end

   // Monitor: every cycle the DUT presents a new output word, compare it with the queued expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            nVec++;
            if (sw_db !== e.db || sw_rise !== e.rise || sw_fall !== e.fall ||
                dig0 !== e.d0 || dig1 !== e.d1) begin
               nFail++;
               $display("[TB] FAIL scoreboard t=%0t got db=%h rise=%h fall=%h d1d0=%h%h want db=%h rise=%h fall=%h d1d0=%h%h",
                        $time, sw_db, sw_rise, sw_fall, dig1, dig0, e.db, e.rise, e.fall, e.d1, e.d0);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] raw, input logic clr, input logic rst_n, input int n);
      sw_raw  = raw;
      cnt_clr = clr;
      rstn    = rst_n;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
      nVec++;
      if (got !== want) begin
         nFail++;
         $display("[TB] FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic doReset();
      applyStimulus(8'h00, 1'b0, 1'b0, 2);
   endtask

   initial begin : stimulus
      logic [7:0] r;
      nVec = 0; nFail = 0; monEnable = 1'b1;
      sw_raw = 8'h00; cnt_clr = 1'b0; rstn = 1'b0;
      @(negedge clk);

      // Reset state
      doReset();
      applyStimulus(8'h00, 1'b0, 1'b1, 1);
      checkOutput("rst_db", sw_db, 8'h00);
      checkOutput("rst_rise", sw_rise, 8'h00);
      checkOutput("rst_fall", sw_fall, 8'h00);
      checkOutput("rst_dig", {dig1, dig0}, 8'h00);

      // Held press: flips on the third tick (cycle 11)
      doReset();
      applyStimulus(8'h01, 1'b0, 1'b1, 11);
      checkOutput("hold_db_before", sw_db, 8'h00);
      applyStimulus(8'h01, 1'b0, 1'b1, 1);
      checkOutput("hold_db_after", sw_db, 8'h01);
      checkOutput("hold_rise", sw_rise, 8'h01);
      applyStimulus(8'h01, 1'b0, 1'b1, 1);
      checkOutput("hold_rise_once", sw_rise, 8'h00);
      checkOutput("hold_dig0", {4'h0, dig0}, 8'h01);

      // Glitch of two ticks is rejected
      doReset();
      applyStimulus(8'h01, 1'b0, 1'b1, 8);
      applyStimulus(8'h00, 1'b0, 1'b1, 20);
      checkOutput("glitch_db", sw_db, 8'h00);
      checkOutput("glitch_dig", {dig1, dig0}, 8'h00);

      // Two bits fall together
      doReset();
      applyStimulus(8'h81, 1'b0, 1'b1, 16);
      checkOutput("two_db", sw_db, 8'h81);
      applyStimulus(8'h00, 1'b0, 1'b1, 16);
      checkOutput("two_fall_db", sw_db, 8'h00);

      // Presses, clear during a press, then 256-press wrap
      doReset();
      for (int p = 0; p < 3; p++) begin
         applyStimulus(8'h01, 1'b0, 1'b1, 16);
         applyStimulus(8'h00, 1'b0, 1'b1, 16);
      end
`ifdef SW_DEBOUNCE_EVT_CNT_EN
      checkOutput("three_presses", {dig1, dig0}, 8'h03);
`endif
      applyStimulus(8'h01, 1'b1, 1'b1, 16);
      applyStimulus(8'h00, 1'b0, 1'b1, 16);
`ifdef SW_DEBOUNCE_EVT_CNT_EN
      checkOutput("clr_wins", {dig1, dig0}, 8'h00);
`endif
      for (int p = 0; p < 256; p++) begin
         applyStimulus(8'h01, 1'b0, 1'b1, 16);
         applyStimulus(8'h00, 1'b0, 1'b1, 16);
      end
`ifdef SW_DEBOUNCE_EVT_CNT_EN
      checkOutput("wrap", {dig1, dig0}, 8'h00);
`endif

      // Reset in mid-count discards the partial count
      doReset();
      applyStimulus(8'h01, 1'b0, 1'b1, 8);
      doReset();
      applyStimulus(8'h01, 1'b0, 1'b1, 10);
      checkOutput("midrst_db_before", sw_db, 8'h00);
      applyStimulus(8'h01, 1'b0, 1'b1, 2);
      checkOutput("midrst_db_after", sw_db, 8'h01);

      // Stable word 0xA5
      doReset();
      applyStimulus(8'hA5, 1'b0, 1'b1, 20);
      checkOutput("a5_db", sw_db, 8'hA5);
`ifndef SW_DEBOUNCE_EVT_CNT_EN
      checkOutput("a5_dig", {dig1, dig0}, 8'hA5);
`endif

      // Randomized phase
      r = 8'h00;
      for (int it = 0; it < 200; it++) begin
         r = r ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
         applyStimulus(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) != 0),
                       $urandom_range(1, 24));
      end

      monEnable = 1'b0;
      repeat (3) @(negedge clk);
      nVec++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("[TB] FAIL queue_drain got=%0d want=0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Switch-conditioning stage directly downstream of the CPLD serial interface. Takes the raw 8-bit switch word that the interface refreshes once per CPLD frame, debounces each bit, and emits stable levels plus one-cycle rise/fall pulses. Drives the two hex-digit inputs of the interface: either a rising-edge event counter or the debounced switch word, selected at compile time.

## Interface
- `SAMPLE_DIV`, 16384: clock cycles per sample tick. Matches one 16-bit CPLD frame. Must be ≥ 2.
- `STABLE_N`, 4: consecutive differing samples required before a bit flips. Must be ≥ 1.
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `sw_raw` in 8: raw switch word. Already in the `clk` domain; no synchronizer.
- `cnt_clr` in 1: synchronous clear of the event counter.
- `sw_db` out 8: debounced switch levels.
- `sw_rise` out 8: per-bit one-cycle pulse on a debounced 0→1 transition.
- `sw_fall` out 8: per-bit one-cycle pulse on a debounced 1→0 transition.
- `dig0` out 4: low hex digit for the display.
- `dig1` out 4: high hex digit for the display.

## Operation
- **Prescaler:** counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted when the count equals SAMPLE_DIV-1. `sw_raw` is only examined on a tick.
- **Per-bit filter:** each bit `i` has a stability counter of width clog2(STABLE_N), minimum 1 bit. On a tick:
  - if `sw_raw[i]` == `sw_db[i]`: counter ← 0.
  - if they differ and the counter == STABLE_N-1: `sw_db[i]` toggles and the counter ← 0.
  - otherwise the counter increments.
  - No state changes on cycles without a tick.
- **Edge pulses:** `sw_rise[i]` / `sw_fall[i]` are registered in the same edge that updates `sw_db[i]`. Each is high for exactly one cycle. Several bits may pulse in the same cycle.
- **Event counter:** 8-bit.
  - Increments by exactly 1 on any cycle where `|sw_rise` is high, regardless of how many bits rose.
  - Wraps 0xFF→0x00.
  - `cnt_clr` has priority over an increment in the same cycle.
- **Digit outputs:** `dig0` = counter[3:0], `dig1` = counter[7:4].
- **Reset:** while `rstn` is low at a clock edge, all of the following are cleared:
  - prescaler and stability counters ← 0
  - `sw_db`, `sw_rise`, `sw_fall` ← 0x00
  - event counter ← 0x00, so `dig0` = `dig1` = 0
  
  A reset mid-filtering discards partial counts. After release, the prescaler restarts from 0.

## Timing
- If `sw_raw[i]` changes and then holds, `sw_db[i]` updates on the clock edge of the STABLE_N-th tick that sees the new value. The rise/fall pulse is visible in the same cycle as the new `sw_db`.
- The event counter updates one cycle after the `sw_rise` pulse. `dig0`/`dig1` are combinational from the counter register.
- A `sw_raw` value that reverts before STABLE_N consecutive ticks produces no `sw_db` change and no pulses.
- The first tick after reset occurs at cycle SAMPLE_DIV-1, counting from the first cycle with `rstn` high.

## Configuration
- `SW_DEBOUNCE_EVT_CNT_EN` defined: the event counter is built, and `dig0`/`dig1` show the counter as described above.
- Undefined:
  - No counter logic is built and `cnt_clr` is ignored.
  - `dig0` = `sw_db[3:0]`, `dig1` = `sw_db[7:4]`.
  - All other behaviour is unchanged.

## Structure
- Package `sw_debounce_pkg` holds:
  - `SW_W` = 8, `EVT_CNT_W` = 8, `DIG_W` = 4
  - the clog2 helper function used to size the stability counter
- One sub-module, `sw_deb_bit`: the per-bit stability counter, level register and rise/fall register, taking `tick`. It is instantiated SW_W times in a generate loop.
- The prescaler, event counter and digit mux stay in the top.

## Test plan
Bench parameters are SAMPLE_DIV=4, STABLE_N=3, with the macro defined unless stated otherwise.
1. `rstn`=0 for 2 cycles, then 1 → `sw_db`=0x00, `sw_rise`=`sw_fall`=0x00, `dig0`=`dig1`=0. First tick at cycle 3.
2. `sw_raw`=0x01 from cycle 0 and held → ticks at cycles 3, 7, 11. `sw_db`=0x01 and `sw_rise`=0x01 after the cycle-11 edge, one cycle only. `dig0`=1 one cycle later.
3. `sw_raw`=0x01 for 2 ticks, then 0x00 → `sw_db` stays 0x00, no pulses, `dig0`=0.
4. `sw_raw` 0x81→0x00 after `sw_db`=0x81 → `sw_fall`=0x81 in a single cycle. The counter is unchanged.
5. Three separate presses → `dig0`=3. Then `cnt_clr` in the same cycle as a `sw_rise` → counter 0. Then 256 presses → counter wraps to 0x00.
6. Reset asserted while a stability count is at 2 → after release, a full 3 ticks are needed to flip. With the macro undefined and `sw_raw`=0xA5 held → `dig0`=5, `dig1`=A.
